// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the core (fetch and load/store paths) and the shared memory.
// slave is the arbiter's view; master is the core-plus-memory environment driving it.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_valid, if_instr, d_done, d_rdata, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_valid, if_instr, d_done, d_rdata, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported 32-bit memory between instruction fetch
// and 16-bit data load/store, with an access timeout and the core stall output.
//
//   state  | meaning
//   -------+-------------------------------------------------
//   S_IDLE | no access in flight, sampling requests for a grant
//   S_BUSY | memory access outstanding, waiting for mem_ack
//   S_RESP | completion pulse cycle, no new grant
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          _reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    typedef enum logic {G_FETCH = 1'b0, G_DATA = 1'b1} grant_t;

    // The counter is cleared on grant, so in BUSY cycle n it holds n-1.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 2);

    state_t      r_state,      w_state_nxt;
    grant_t      r_last_grant, w_last_grant_nxt;
    grant_t      r_gnt,        w_gnt_nxt;
    logic [7:0]  r_cnt,        w_cnt_nxt;
    logic        r_mem_req,    w_mem_req_nxt;
    logic        r_mem_we,     w_mem_we_nxt;
    logic [31:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic [31:0] r_if_instr,   w_if_instr_nxt;
    logic [15:0] r_d_rdata,    w_d_rdata_nxt;
    logic        r_if_valid,   w_if_valid_nxt;
    logic        r_d_done,     w_d_done_nxt;
    logic        r_bus_err,    w_bus_err_nxt;

    always_ff @(posedge clk) begin
        if (_reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= G_FETCH;
            r_gnt        <= G_FETCH;
            r_cnt        <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_if_instr   <= 32'd0;
            r_d_rdata    <= 16'd0;
            r_if_valid   <= 1'b0;
            r_d_done     <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_gnt        <= w_gnt_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_d_done     <= w_d_done_nxt;
            r_bus_err    <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_gnt_nxt        = r_gnt;
        w_cnt_nxt        = r_cnt;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_if_instr_nxt   = r_if_instr;
        w_d_rdata_nxt    = r_d_rdata;
        w_if_valid_nxt   = 1'b0;
        w_d_done_nxt     = 1'b0;
        w_bus_err_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    if (bus.if_req && bus.d_req) begin
                        w_gnt_nxt = (r_last_grant == G_FETCH) ? G_DATA : G_FETCH;
                    end else begin
                        w_gnt_nxt = bus.d_req ? G_DATA : G_FETCH;
                    end
                    if (w_gnt_nxt == G_DATA) begin
                        w_mem_addr_nxt  = bus.d_addr;
                        w_mem_we_nxt    = bus.d_we;
                        w_mem_wdata_nxt = bus.d_we ? {16'd0, bus.d_wdata} : 32'd0;
                    end else begin
                        w_mem_addr_nxt  = bus.if_addr;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_wdata_nxt = 32'd0;
                    end
                    w_cnt_nxt     = 8'd0;
                    w_mem_req_nxt = 1'b1;
                    w_state_nxt   = S_BUSY;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt + 8'd1;
                // An ack on the last allowed cycle beats the timeout.
                if (bus.mem_ack) begin
                    if (r_gnt == G_FETCH) begin
                        w_if_instr_nxt = bus.mem_rdata;
                    end else if (!r_mem_we) begin
                        w_d_rdata_nxt = bus.mem_rdata[15:0];
                    end
                    w_last_grant_nxt = r_gnt;
                    w_mem_req_nxt    = 1'b0;
                    w_mem_we_nxt     = 1'b0;
                    w_if_valid_nxt   = (r_gnt == G_FETCH);
                    w_d_done_nxt     = (r_gnt == G_DATA);
                    w_state_nxt      = S_RESP;
                end else if (r_cnt == LP_CNT_LAST) begin
                    if (r_gnt == G_FETCH) begin
                        w_if_instr_nxt = 32'd0;
                    end else begin
                        w_d_rdata_nxt = 16'd0;
                    end
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_if_valid_nxt = (r_gnt == G_FETCH);
                    w_d_done_nxt   = (r_gnt == G_DATA);
                    w_bus_err_nxt  = 1'b1;
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.d_done    = r_d_done;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.bus_err   = r_bus_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.stall     = ~_reset & ((bus.if_req & ~r_if_valid) | (bus.d_req & ~r_d_done));
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level timeline model predicts grant order,
// memory window, completion cycle and read data for each access, checked cycle by cycle.
module tb_mem_arbiter;
    localparam int TO     = 4;
    localparam int N_CYC  = 3000;
    localparam int RST_AT = 1500;

    logic clk = 1'b0;
    logic reset_in;
    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TO)) u_dut (
        .clk    (clk),
        ._reset (reset_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // core-side requests
    bit          if_pend, d_pend, force_both;
    logic [31:0] if_a, d_a;
    logic        d_w;
    logic [15:0] d_wd;
    // current access: grant cycle, last memory cycle, pulse cycle, next grantable cycle
    bit          m_side, m_ok, m_we, last_grant;
    int          m_start, m_end, m_done, m_free_at;
    logic [31:0] m_addr, m_wdata, m_data;
    logic [31:0] exp_instr;
    logic [15:0] exp_drd;
    bit          rst_now, rst_done, in_busy, ack, exp_pulse;
    int          dly;

    initial begin
        reset_in      = 1'b1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h10;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h4;
        bus.d_wdata   = 16'hA5A5;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_req",   bus.mem_req,   0);
        check_eq("rst_mem_we",    bus.mem_we,    0);
        check_eq("rst_mem_addr",  bus.mem_addr,  0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_if_valid",  bus.if_valid,  0);
        check_eq("rst_if_instr",  bus.if_instr,  0);
        check_eq("rst_d_done",    bus.d_done,    0);
        check_eq("rst_d_rdata",   bus.d_rdata,   0);
        check_eq("rst_bus_err",   bus.bus_err,   0);
        check_eq("rst_stall",     bus.stall,     0);

        m_start = -100; m_end = -100; m_done = -100; m_free_at = 0;
        last_grant = 1'b0; exp_instr = '0; exp_drd = '0;
        if_pend = 1'b0; d_pend = 1'b0; force_both = 1'b1; rst_done = 1'b0;
        m_side = 1'b0; m_ok = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_data = '0;

        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            rst_now = !rst_done && (c >= RST_AT) && (c > m_start) && (c <= m_end);

            if (force_both) begin
                if_pend = 1'b1; if_a = $urandom;
                d_pend = 1'b1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = 16'($urandom);
                force_both = 1'b0;
            end else begin
                if (!if_pend && $urandom_range(0, 3) != 0) begin
                    if_pend = 1'b1; if_a = $urandom;
                end
                if (!d_pend && $urandom_range(0, 3) != 0) begin
                    d_pend = 1'b1; d_a = $urandom; d_w = 1'($urandom_range(0, 1)); d_wd = 16'($urandom);
                end
            end
            bus.if_req  = if_pend;
            bus.if_addr = if_pend ? if_a : $urandom;
            bus.d_req   = d_pend;
            bus.d_we    = d_pend ? d_w : 1'($urandom_range(0, 1));
            bus.d_addr  = d_pend ? d_a : $urandom;
            bus.d_wdata = d_pend ? d_wd : 16'($urandom);

            if (!rst_now && c >= m_free_at && (if_pend || d_pend)) begin
                m_side  = (if_pend && d_pend) ? ~last_grant : d_pend;
                dly     = $urandom_range(1, 5);
                m_ok    = (dly <= TO - 1);
                m_start = c;
                m_end   = c + (m_ok ? dly : TO - 1);
                m_done  = m_end + 1;
                m_free_at = m_done + 1;
                m_data  = $urandom;
                if (m_side) begin
                    m_addr = d_a; m_we = d_w; m_wdata = d_w ? {16'h0, d_wd} : 32'h0;
                end else begin
                    m_addr = if_a; m_we = 1'b0; m_wdata = 32'h0;
                end
                if (m_ok) last_grant = m_side;
            end

            in_busy = (c > m_start) && (c <= m_end);
            if (in_busy) ack = !rst_now && m_ok && (c == m_end);
            else         ack = ($urandom_range(0, 3) == 0);
            bus.mem_ack   = ack;
            bus.mem_rdata = (in_busy && ack) ? m_data : $urandom;
            reset_in      = rst_now;
            #1;

            exp_pulse = (c == m_done);
            if (exp_pulse) begin
                if (!m_side)    exp_instr = m_ok ? m_data : 32'h0;
                else if (!m_ok) exp_drd = 16'h0;
                else if (!m_we) exp_drd = m_data[15:0];
            end

            check_eq("mem_req", bus.mem_req, in_busy);
            if (in_busy) begin
                check_eq("mem_addr", bus.mem_addr, m_addr);
                check_eq("mem_we",   bus.mem_we,   m_we);
                if (m_we || !m_side) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
            end
            check_eq("if_valid", bus.if_valid, exp_pulse && !m_side);
            check_eq("d_done",   bus.d_done,   exp_pulse && m_side);
            check_eq("bus_err",  bus.bus_err,  exp_pulse && !m_ok);
            check_eq("if_instr", bus.if_instr, exp_instr);
            check_eq("d_rdata",  bus.d_rdata,  exp_drd);
            check_eq("stall", bus.stall,
                     !rst_now && ((if_pend && !(exp_pulse && !m_side)) ||
                                  (d_pend && !(exp_pulse && m_side))));

            if (exp_pulse) begin
                if (m_side) d_pend = 1'b0;
                else        if_pend = 1'b0;
            end
            if (rst_now) begin
                rst_done = 1'b1;
                m_start = -100; m_end = -100; m_done = -100; m_free_at = c + 1;
                last_grant = 1'b0; exp_instr = '0; exp_drd = '0;
                if_pend = 1'b0; d_pend = 1'b0; force_both = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported 32-bit memory between the core's instruction-fetch path and its 16-bit data load/store path. Each side presents a request and receives a one-cycle completion pulse with registered read data. A small FSM holds the memory handshake, alternates grants round-robin under contention and aborts accesses the memory never acknowledges. It produces the core's `stall` so the instruction pointer and register writes freeze until the needed access completes.

## Interface
- `TIMEOUT`, default 255: cycles in BUSY without `mem_ack` before the access is aborted; legal range 2..255.
- `clk` in 1: single clock, all state updates on rising edge.
- `_reset` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held with `if_addr` stable until `if_valid`.
- `if_addr` in 32: fetch word address.
- `if_valid` out 1: one-cycle fetch completion pulse.
- `if_instr` out 32: fetched instruction, valid while `if_valid`.
- `d_req` in 1: data request, held with `d_we`/`d_addr`/`d_wdata` stable until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data word address.
- `d_wdata` in 16: store data.
- `d_done` out 1: one-cycle data completion pulse.
- `d_rdata` out 16: load data, valid while `d_done`.
- `bus_err` out 1: pulses together with `if_valid`/`d_done` when the access timed out.
- `mem_req` out 1: memory request, held until `mem_ack` or abort.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: `{16'b0, d_wdata}` on stores, 0 on fetches.
- `mem_ack` in 1: one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read data.
- `stall` out 1: core hold request.

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: memory access outstanding.
  - RESP: completion cycle.
- IDLE:
  - Sample `if_req`/`d_req`. With none asserted, stay in IDLE.
  - With exactly one asserted, grant it. With both asserted, grant the side not granted last.
  - `last_grant` resets to FETCH, so the first contention grants data.
  - On a grant, latch address, we and wdata into `mem_*` registers, clear the timeout counter, go to BUSY.
- BUSY:
  - `mem_req`=1; `mem_*` stay stable. The counter increments each cycle.
  - On `mem_ack`:
    - Register `mem_rdata` into `if_instr` (fetch), or register `mem_rdata[15:0]` into `d_rdata` (load); stores leave `d_rdata` unchanged.
    - Update `last_grant`, go to RESP.
  - If the counter reaches `TIMEOUT-1` without ack:
    - Deassert `mem_req`, zero the read-data register of the granted side, set the error flag, go to RESP.
- RESP:
  - Pulse `if_valid` or `d_done` for the granted side, plus `bus_err` if aborted. Go to IDLE.
  - No new grant in RESP. A requester still holding req in RESP is ignored that cycle.
  - A req seen in the following IDLE is a new request.
- `mem_ack` outside BUSY is ignored. The memory must not ack after `mem_req` drops.
- `stall` = `(if_req & ~if_valid) | (d_req & ~d_done)`, forced 0 while `_reset`=1.

## Timing
- Reset:
  - State → IDLE, `last_grant` → FETCH, counter → 0.
  - `mem_req`, `mem_we`, `if_valid`, `d_done`, `bus_err` → 0.
  - `mem_addr`, `mem_wdata`, `if_instr`, `d_rdata` → 0.
- Reset mid-operation:
  - The in-flight access is abandoned and no completion pulse is emitted.
  - `mem_req` is low the cycle after the reset edge.
- Latency: request seen in IDLE at cycle 0 → `mem_req` high cycle 1 → ack at cycle k≥1 → pulse at cycle k+1 → IDLE at k+2.
  - Minimum request-to-completion is 2 cycles.
  - Maximum throughput is one access per 3 cycles.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT-1` cycles (1..TIMEOUT-1); the error pulse follows in cycle TIMEOUT.
- `mem_ack` arriving in the same cycle the counter hits `TIMEOUT-1` counts as success: ack wins.
- All outputs except `stall` are registered.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x10, memory acks on the 1st BUSY cycle with 0xDEADBEEF → `if_valid` pulse at cycle 2 with `if_instr`=0xDEADBEEF. `stall`=1 in cycles 0-1 and 0 in cycle 2.
- Store then load:
  - Store with `d_addr`=4, `d_wdata`=0xA5A5, ack after 3 BUSY cycles → `mem_we`=1, `mem_wdata`=0x0000A5A5, `d_done` at cycle 4.
  - Load from address 4, with the memory returning 0x1234A5A5 on ack → `d_rdata`=0xA5A5.
- Contention: `if_req` and `d_req` asserted together and held → grant order data, fetch, data. Each completion pulses only its own side.
- Timeout with `TIMEOUT`=4 and `mem_ack` tied 0 → `mem_req` high for 3 cycles, then `d_done`=1 with `bus_err`=1 and `d_rdata`=0. A subsequent normal access succeeds with `bus_err`=0.
- Ack at the limit: with `TIMEOUT`=4, ack in the 3rd BUSY cycle → `bus_err`=0 and data is captured.
- Reset mid-access: `_reset` pulsed in BUSY → no completion pulse, all outputs 0 next cycle. A late `mem_ack` in IDLE is ignored.
